pulse_stretcher: RTL and testbench

Output-side counterpart to the input debounce/pulser stage. It takes single-cycle event pulses from the fabric and turns each one into a fixed-width, human-visible high interval on an LED or indicator pin. Consecutive intervals are separated by a guaranteed low gap so every event remains distinguishable. Events that arrive while an interval is in progress are queued in a saturating pending counter and replayed in order.

---
 rtl/pulse_stretcher.sv | 140 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-width high intervals separated by a low gap.
// Events that arrive during an interval are queued in a saturating counter and replayed in order.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 5_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int CNT_WIDTH   = 24,
    parameter int PEND_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  I,
    output logic                  O,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  drop,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  HIGH_LOAD = CNT_WIDTH'(HIGH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  GAP_LOAD  = CNT_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [PEND_WIDTH-1:0] r_pending;
    logic                  r_drop;
    logic                  r_o;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [PEND_WIDTH-1:0] w_pend_nxt;
    logic                  w_drop_nxt;
    logic                  w_cnt_zero;
    logic                  w_restart;
    logic                  w_enqueue;

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pending;
        w_drop_nxt  = 1'b0;
        w_restart   = 1'b0;
        w_enqueue   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (I) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = HIGH_LOAD;
                end
            end
            S_HIGH: begin
                if (w_cnt_zero) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = GAP_LOAD;
                        w_enqueue   = I;
                    end else begin
                        w_restart = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
                    w_enqueue = I;
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    w_restart = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
                    w_enqueue = I;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // End of a gap: older queued events take priority; a coincident new event
        // replaces the one dequeued, so the count is unchanged.
        if (w_restart) begin
            if (r_pending != '0) begin
                w_state_nxt = S_HIGH;
                w_cnt_nxt   = HIGH_LOAD;
                if (!I) begin
                    w_pend_nxt = r_pending - PEND_WIDTH'(1);
                end
            end else if (I) begin
                w_state_nxt = S_HIGH;
                w_cnt_nxt   = HIGH_LOAD;
            end else begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        end

        if (w_enqueue) begin
            if (r_pending == PEND_MAX) begin
                w_drop_nxt = 1'b1;
            end else begin
                w_pend_nxt = r_pending + PEND_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_drop    <= 1'b0;
            r_o       <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pend_nxt;
            r_drop    <= w_drop_nxt;
            r_o       <= (w_state_nxt == S_HIGH);
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign O           = r_o;
    assign busy        = r_busy;
    assign pending     = r_pending;
    assign drop        = r_drop;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed-vector bench for pulse_stretcher: per-cycle expected outputs are queued by the
// driver and popped by independent monitors on the falling edge.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_a = 1'b0;
    logic       i_b = 1'b0;
    logic       o_a, busy_a, drop_a;
    logic [1:0] pend_a, st_a;
    logic       o_b, busy_b, drop_b;
    logic [1:0] pend_b, st_b;

    logic [4:0] exp_a_q[$];
    logic [4:0] exp_b_q[$];
    string      name_a_q[$];
    string      name_b_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .CNT_WIDTH(4), .PEND_WIDTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .I(i_a), .O(o_a), .busy(busy_a),
        .pending(pend_a), .drop(drop_a), .o_dbg_state(st_a)
    );

    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(0), .CNT_WIDTH(4), .PEND_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .I(i_b), .O(o_b), .busy(busy_b),
        .pending(pend_b), .drop(drop_b), .o_dbg_state(st_b)
    );

    function automatic logic [1:0] ch2v(input byte c);
        return 2'(c - 8'd48);
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_a_q.size() > 0) begin
            logic [4:0] e, a;
            string      n;
            e = exp_a_q.pop_front();
            n = name_a_q.pop_front();
            a = {o_a, busy_a, pend_a, drop_a};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got O/busy/pending/drop=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                         n, a[4], a[3], a[2:1], a[0], e[4], e[3], e[2:1], e[0]);
            end
        end
    end

    always @(negedge clk) begin
        if (exp_b_q.size() > 0) begin
            logic [4:0] e, a;
            string      n;
            e = exp_b_q.pop_front();
            n = name_b_q.pop_front();
            a = {o_b, busy_b, pend_b, drop_b};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got O/busy/pending/drop=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                         n, a[4], a[3], a[2:1], a[0], e[4], e[3], e[2:1], e[0]);
            end
        end
    end

    // Character k of each string is the value during cycle k (after posedge k).
    task automatic run_vec(input bit sel, input string nm, input string i_s, input string o_s,
                           input string b_s, input string p_s, input string d_s);
        logic [1:0] iv, ov, bv, pv, dv;
        for (int k = 0; k < i_s.len(); k++) begin
            @(posedge clk);
            #1;
            iv = ch2v(i_s[k]);
            ov = ch2v(o_s[k]);
            bv = ch2v(b_s[k]);
            pv = ch2v(p_s[k]);
            dv = ch2v(d_s[k]);
            if (sel) begin
                i_b = iv[0];
                exp_b_q.push_back({ov[0], bv[0], pv, dv[0]});
                name_b_q.push_back($sformatf("%s[%0d]", nm, k));
            end else begin
                i_a = iv[0];
                exp_a_q.push_back({ov[0], bv[0], pv, dv[0]});
                name_a_q.push_back($sformatf("%s[%0d]", nm, k));
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst0_O",       {7'd0, o_a},    8'd0);
        check("rst0_busy",    {7'd0, busy_a}, 8'd0);
        check("rst0_pending", {6'd0, pend_a}, 8'd0);
        check("rst0_drop",    {7'd0, drop_a}, 8'd0);
        check("rst0_state",   {6'd0, st_a},   8'd0);
        check("rst0_b_O",     {7'd0, o_b},    8'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_vec(1'b0, "single",
                "10000000", "01111000", "01111110", "00000000", "00000000");
        run_vec(1'b0, "queued",
                "10100000000000", "01111001111000", "01111111111110",
                "00011110000000", "00000000000000");
        run_vec(1'b0, "saturate",
                "111111000000000000000000000", "011110011110011110011110000",
                "011111111111111111111111100", "001233322222211111100000000",
                "000001100000000000000000000");
        run_vec(1'b0, "simul_gap_end",
                "10100010000000000000", "01111001111001111000",
                "01111111111111111110", "00011111111110000000",
                "00000000000000000000");
        run_vec(1'b1, "gap0",
                "1100000000", "0111111110", "0111111110", "0011100000", "0000000000");

        run_vec(1'b0, "pre_reset",
                "10110", "01111", "01111", "00012", "00000");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_O",       {7'd0, o_a},    8'd0);
        check("rst_mid_busy",    {7'd0, busy_a}, 8'd0);
        check("rst_mid_pending", {6'd0, pend_a}, 8'd0);
        check("rst_mid_drop",    {7'd0, drop_a}, 8'd0);
        check("rst_mid_state",   {6'd0, st_a},   8'd0);
        i_a = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_vec(1'b0, "post_reset",
                "00000000100000000", "00000000011110000", "00000000011111100",
                "00000000000000000", "00000000000000000");

        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
